// File: rtl/mult_datapath_if.sv
// Signal bundle between the shift-add multiply controller and its datapath.
// Handshake: rdy is a level from the controller. While it is high the datapath
// freezes. product_valid is rdy delayed by one clock and marks a stable result.
interface mult_datapath_if;
  logic [31:0] multiplicand_in;
  logic [31:0] multiplier_in;
  logic        w_ctrl_Multiplicand;
  logic        w_ctrl_Product;
  logic        adding_ctrl;
  logic [5:0]  addu_ctrl;
  logic        rdy;
  logic        lsb;
  logic [63:0] product;
  logic        product_valid;
  logic        alu_op_err;

  modport master (
    output multiplicand_in, multiplier_in, w_ctrl_Multiplicand, w_ctrl_Product,
           adding_ctrl, addu_ctrl, rdy,
    input  lsb, product, product_valid, alu_op_err
  );

  modport slave (
    input  multiplicand_in, multiplier_in, w_ctrl_Multiplicand, w_ctrl_Product,
           adding_ctrl, addu_ctrl, rdy,
    output lsb, product, product_valid, alu_op_err
  );
endinterface

// File: rtl/mult_datapath.sv
// Shift-add datapath for an unsigned 32x32 multiply. One load edge is followed
// by 32 iterate edges. The controller steers it through lsb and the w_ctrl bits.
module mult_datapath (
  input  logic            clk,
  input  logic            rst,
  mult_datapath_if.slave  bus
);
  localparam logic [5:0] OP_ADDU = 6'b001001;

  logic [31:0] mcand_q, mcand_d;
  logic [63:0] prod_q, prod_d;
  logic        carry_q, carry_d;
  logic        err_q, err_d;
  logic        valid_q;
  logic        add_legal;
  logic        add_illegal;
  logic [32:0] sum;

  always_comb begin
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    carry_d     = carry_q;
    err_d       = err_q;
    add_legal   = bus.adding_ctrl && (bus.addu_ctrl == OP_ADDU);
    add_illegal = bus.adding_ctrl && (bus.addu_ctrl != OP_ADDU);
    // The 33-bit sum keeps the add carry, so the shift moves it into product[63].
    sum = {carry_q, prod_q[63:32]} + (add_legal ? {1'b0, mcand_q} : 33'd0);
    if (!bus.rdy) begin
      if (!bus.w_ctrl_Multiplicand) begin
        mcand_d = bus.multiplicand_in;
      end
      if (!bus.w_ctrl_Product) begin
        prod_d  = {32'h0, bus.multiplier_in};
        carry_d = 1'b0;
      end else begin
        prod_d  = {sum, prod_q[31:1]};
        carry_d = 1'b0;
        if (add_illegal) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= 32'h0;
      prod_q  <= 64'h0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      valid_q <= bus.rdy;
    end
  end

  assign bus.lsb           = prod_q[0];
  assign bus.product       = prod_q;
  assign bus.product_valid = valid_q;
  assign bus.alu_op_err    = err_q;
endmodule
